// File: rtl/rd_wait_responder.sv
// Peripheral-side responder for the rd/ws/ds read strobes: inserts wait_cfg ws cycles, captures read data on ds.
// Optional RD_TIMEOUT_EN: abandons a transaction after TMO rd cycles without ds and pulses tmo_err.
module rd_wait_responder #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int CNT_W = 3,
  parameter int TMO   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd,
  input  logic             ds,
  input  logic [CNT_W-1:0] wait_cfg,
  input  logic [AW-1:0]    addr_in,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  output logic             ws,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef RD_TIMEOUT_EN
  output logic             tmo_err,
`endif
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start, cap, tmo;

  if (TMO < 1) begin : g_tmo_chk
    $error("TMO must be at least 1");
  end

`ifdef RD_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] rdcnt;

  // ds on the same edge as the limit takes priority over the timeout
  always_comb tmo = (state != IDLE) && rd && !ds && (rdcnt == TW'(TMO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdcnt   <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= tmo;
      if (start)                    rdcnt <= '0;
      else if (state != IDLE && rd) rdcnt <= rdcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: if (rd) begin
        start     = 1'b1;
        cnt_nxt   = wait_cfg;
        state_nxt = (wait_cfg != '0) ? WAIT : READY;
      end
      WAIT: begin
        if (ds) begin
          cap       = 1'b1;
          state_nxt = IDLE;
        end else if (rd) begin
          if (cnt != '0)         cnt_nxt   = cnt - 1'b1;
          if (cnt == CNT_W'(1))  state_nxt = READY;
        end
      end
      READY: if (ds) begin
        cap       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo) state_nxt = IDLE;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ws        <= 1'b0;
      mem_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ws    <= (state_nxt == WAIT);
      if (start) mem_addr <= addr_in;
      // a held, unaccepted word blocks capture; the new word is lost and flagged
      if (cap && !(out_valid && !out_ready)) begin
        out_data  <= mem_rdata;
        out_valid <= 1'b1;
      end else begin
        if (cap)                   ovf       <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rd_wait_responder.sv
// Scoreboard bench for rd_wait_responder: directed transactions push expected words, a monitor pops on handshakes.
module tb_rd_wait_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd, ds, out_ready;
  logic [2:0] wait_cfg;
  logic [3:0] addr_in, mem_addr;
  logic [7:0] mem_rdata, out_data;
  logic       ws, out_valid, busy, ovf;
`ifdef RD_TIMEOUT_EN
  logic       tmo_err;
`endif

  int pass_cnt = 0;
  int total    = 0;
  logic [7:0] exp_q[$];

  rd_wait_responder #(.DW(8), .AW(4), .CNT_W(3), .TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .ds(ds), .wait_cfg(wait_cfg), .addr_in(addr_in),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .ws(ws), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef RD_TIMEOUT_EN
    .tmo_err(tmo_err),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: a handshake seen at negedge transfers on the next rising edge
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL out_unexpected: got %0h expected no word", out_data);
      end else begin
        chk("out_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // one controller transaction: start, ws loop (rd low for gap cycles), one READY rd cycle, ds
  task automatic txn(input logic [2:0] cfg, input logic [3:0] addr, input logic [7:0] data,
                     input logic rdy, input bit push, input int gap);
    int nws;
    wait_cfg = cfg; addr_in = addr; mem_rdata = data; rd = 1'b1;
    step();
    chk("busy_start", {31'b0, busy}, 32'd1);
    nws = 0;
    for (int k = 0; k < 40 && ws; k++) begin
      nws++;
      rd = (k == 0 || k > gap);
      step();
    end
    chk("ws_cycles", nws, int'(cfg) + gap);
    rd = 1'b1;
    step();
    rd = 1'b0; ds = 1'b1; out_ready = rdy;
    if (push) exp_q.push_back(data);
    step();
    ds = 1'b0;
    chk("valid_lat", {31'b0, out_valid}, 32'd1);
    chk("idle_after", {30'b0, busy, ws}, 32'd0);
    chk("mem_addr", {28'b0, mem_addr}, {28'b0, addr});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rd = 0; ds = 0; out_ready = 0; wait_cfg = 0; addr_in = 0; mem_rdata = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {ws, busy, out_valid, ovf, mem_addr, out_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // zero wait
    out_ready = 1'b1;
    txn(3'd0, 4'd3, 8'hA5, 1'b1, 1'b1, 0);
    ds = 1'b1;
    step();
    ds = 1'b0;
    chk("ds_idle_ignored", {30'b0, busy, out_valid}, 32'd0);

    // two waits, then with rd dropped mid-wait, then maximum wait
    txn(3'd2, 4'd4, 8'h5A, 1'b1, 1'b1, 0);
    txn(3'd2, 4'd6, 8'h3C, 1'b1, 1'b1, 2);
    txn(3'd7, 4'd15, 8'hFF, 1'b1, 1'b1, 0);
    step();

    // backpressure: second word dropped
    out_ready = 1'b0;
    txn(3'd1, 4'd1, 8'h11, 1'b0, 1'b1, 0);
    chk("ovf_first", {31'b0, ovf}, 32'd0);
    txn(3'd0, 4'd2, 8'h22, 1'b0, 1'b0, 0);
    chk("ovf_drop", {31'b0, ovf}, 32'd1);
    chk("data_kept", {24'b0, out_data}, 32'h11);
    out_ready = 1'b1;
    step();
    chk("valid_drop", {31'b0, out_valid}, 32'd0);

    // pop and capture on the same edge
    apply_reset();
    out_ready = 1'b0;
    txn(3'd0, 4'd5, 8'h11, 1'b0, 1'b1, 0);
    txn(3'd0, 4'd6, 8'h33, 1'b1, 1'b1, 0);
    chk("popcap_data", {24'b0, out_data}, 32'h33);
    chk("popcap_ovf", {31'b0, ovf}, 32'd0);
    step();
    chk("popcap_drain", {31'b0, out_valid}, 32'd0);

    // asynchronous reset mid-wait with a held word
    out_ready = 1'b0;
    txn(3'd0, 4'd2, 8'h55, 1'b0, 1'b0, 0);
    wait_cfg = 3'd7; addr_in = 4'd8; rd = 1'b1;
    step();
    step();
    chk("wait_ws", {30'b0, busy, ws}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {ws, busy, out_valid, ovf, mem_addr, out_data}, 32'd0);
    rd = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    txn(3'd3, 4'd9, 8'hC3, 1'b1, 1'b1, 0);
    step();

`ifdef RD_TIMEOUT_EN
    begin
      int n;
      wait_cfg = 3'd0; addr_in = 4'd7; rd = 1'b1;
      step();
      n = 0;
      while (!tmo_err && n < 40) begin
        step();
        n++;
      end
      rd = 1'b0;
      chk("tmo_cycles", n, 15);
      chk("tmo_idle", {30'b0, busy, out_valid}, 32'd0);
      step();
      chk("tmo_pulse", {31'b0, tmo_err}, 32'd0);
    end
`endif

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/rd_wait_responder.md
Name: rd_wait_responder

Overview:
- Peripheral-side responder for the rd/ws/ds read-strobe FSM.
- Sits directly downstream of the read controller: consumes its rd and ds strobes and generates ws for a programmable number of wait cycles.
- Captures memory read data when ds arrives and presents it to the next stage on a valid/ready handshake.

Parameters:
DW, 8, data width of mem_rdata / out_data
AW, 4, address width of addr_in / mem_addr
CNT_W, 3, width of wait_cfg and of the internal wait counter
TMO, 15, rd-high cycle limit used only when RD_TIMEOUT_EN is defined

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd  input  1  read strobe from read controller
ds  input  1  done strobe from read controller
wait_cfg  input  CNT_W  number of ws-high cycles per transaction, sampled at start
addr_in  input  AW  transaction address, sampled at start
mem_addr  output  AW  registered address to memory
mem_rdata  input  DW  memory read data, valid while mem_addr is stable
ws  output  1  wait-state to read controller (registered)
out_data  output  DW  captured read data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accept
busy  output  1  high when state != IDLE
ovf  output  1  sticky overflow flag: result dropped

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, ws=0, mem_addr=0, out_data=0, out_valid=0, ovf=0. Reset mid-transaction aborts it immediately; no partial capture.
- States: IDLE, WAIT, READY.
- IDLE to WAIT/READY: on a clock edge with rd=1.
  - Load cnt=wait_cfg and mem_addr=addr_in.
  - Next state is WAIT if wait_cfg!=0, otherwise READY.
- ws is registered, ws = (state==WAIT).
  - First possible ws-high cycle is the cycle after the first rd cycle.
- WAIT: each edge with rd=1 decrements cnt. When cnt==1 at the edge, go to READY.
  - Result: ws is high for exactly wait_cfg consecutive cycles when rd is held.
  - Edge with rd=0 in WAIT: cnt holds.
- READY: ws=0; wait for ds.
- ds=1 at an edge in WAIT or READY:
  - Capture out_data<=mem_rdata, out_valid<=1, state<=IDLE, ws<=0.
  - ds in IDLE is ignored.
- rd and ds both high in IDLE: treated as start only; ds is ignored.
- Output handshake:
  - Transfer occurs on an edge with out_valid&out_ready; out_valid clears unless a new capture happens on the same edge.
  - Capture while out_valid=1 and out_ready=1: the old word is consumed and the new word loaded; out_valid stays 1.
  - Capture while out_valid=1 and out_ready=0: the new word is dropped, out_data is unchanged, and ovf<=1.
  - ovf clears only on reset.
- Latency: ds edge to out_valid=1 is 1 cycle.
- mem_addr holds its value until the next start; there is no auto-increment.
- Arithmetic: cnt is unsigned CNT_W bits and never decrements below 0. wait_cfg=2^CNT_W-1 gives the maximum wait.

Optional Feature:
RD_TIMEOUT_EN
- Defined:
  - Adds an output tmo_err (1 bit, reset 0) and an internal rd-cycle counter, cleared at start.
  - If the count reaches TMO in WAIT or READY without ds, then: state<=IDLE, ws<=0, no capture, and tmo_err pulses high for exactly 1 cycle.
  - ds on the same edge as the timeout wins: normal capture, no tmo_err.
- Undefined: no tmo_err port and no counter; the block waits for ds indefinitely.

Test Plan:
1. Zero wait: wait_cfg=0, addr_in=3, mem_rdata=8'hA5, controller go pulse.
   -> ws never high; rd high 2 cycles; ds 1 cycle; out_valid=1 with out_data=8'hA5 one cycle after ds; mem_addr=3.
2. Two wait cycles: wait_cfg=2, controller go at edge T.
   -> ws high cycles T+1..T+2; controller loops s1/s2 once extra; rd high 4 cycles; ds at T+4; out_valid at T+5.
3. Backpressure: out_ready=0, two back-to-back transactions with data 8'h11 then 8'h22.
   -> out_data stays 8'h11; ovf=1 after the second ds.
   Follow-up: out_ready=1 -> out_valid drops next cycle.
4. Simultaneous pop and capture: out_valid=1 holding 8'h11, out_ready=1 on the same edge as ds with mem_rdata=8'h33.
   -> out_data=8'h33, out_valid stays 1, ovf stays 0.
5. Reset mid-wait: wait_cfg=7, assert rst_n=0 asynchronously in WAIT.
   -> ws, busy, and out_valid go 0 immediately without waiting for a clock edge; after release, state is IDLE and a new go completes normally.
6. RD_TIMEOUT_EN defined, TMO=15: hold rd=1, never assert ds.
   -> tmo_err pulses 1 cycle when the rd-cycle count reaches 15; busy=0 the next cycle; out_valid stays 0.
